// File: rtl/uart_dumper.sv
// uart_dumper: reads DUMP_BYTES of LPDDR over one MCB read port and sends them on uart_tx as 8N1.
// Define UART_DUMP_CHECKSUM_EN to append a 16-bit byte-sum trailer (high byte first).

module uart_dumper #(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned DUMP_BYTES  = 65536,
  parameter int unsigned BURST_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  progress,
  output logic        uart_tx,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_empty,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_full,
  input  logic        mem_rd_empty,
  input  logic [6:0]  mem_rd_count,
  input  logic        mem_rd_overflow,
  input  logic        mem_rd_error
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW           = $clog2(DUMP_BYTES);
  localparam int unsigned NUM_BURSTS   = DUMP_BYTES / (4 * BURST_WORDS);
  localparam int unsigned BIW          = $clog2(NUM_BURSTS + 1);
  localparam int unsigned WW           = $clog2(BURST_WORDS + 1);
  localparam logic [29:0] BURST_STRIDE = 30'(4 * BURST_WORDS);

  typedef enum logic [2:0] {StIdle, StCmd, StWait, StPop, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     shreg_q, shreg_d;
  logic [WW-1:0]   word_q, word_d;
  logic [BIW-1:0]  burst_q, burst_d;
  logic [29:0]     addr_q, addr_d;
  logic [AW-1:0]   sent_q, sent_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q;
  logic            word_done, dump_done;
  logic [2:0]      data_idx;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [15:0]     sum_q, sum_d;
  logic            trailer_q, trailer_d;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{mem_cmd_empty, mem_rd_full, mem_rd_count};

  assign mem_cmd_instr     = 3'b001;
  assign mem_cmd_bl        = 6'(BURST_WORDS - 1);
  assign mem_cmd_byte_addr = addr_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
`ifdef UART_DUMP_CHECKSUM_EN
  assign progress = trailer_q ? 8'hFF : sent_q[AW-1 -: 8];
`else
  assign progress = sent_q[AW-1 -: 8];
`endif

  // Frame bits: 0 = start, 1..8 = data LSB first, 9 = stop.
  always_comb begin
    data_idx = 3'(bit_q - 4'd1);
    uart_tx  = 1'b1;
    if (state_q == StSend) begin
      if (bit_q == 4'd0)      uart_tx = 1'b0;
      else if (bit_q != 4'd9) uart_tx = shreg_q[data_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    word_d     = word_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    sent_d     = sent_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mem_cmd_en = 1'b0;
    mem_rd_en  = 1'b0;
    word_done  = 1'b0;
    dump_done  = 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
    sum_d      = sum_q;
    trailer_d  = trailer_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Drain words stranded by an aborted dump.
        mem_rd_en = ~mem_rd_empty;
        if (start && calib_done) begin
          state_d = StCmd;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          sent_d  = '0;
          burst_d = '0;
          word_d  = '0;
          addr_d  = 30'(BASE_ADDR);
`ifdef UART_DUMP_CHECKSUM_EN
          sum_d     = '0;
          trailer_d = 1'b0;
`endif
        end
      end
      StCmd: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          addr_d     = addr_q + BURST_STRIDE;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (!mem_rd_empty) state_d = StPop;
      end
      StPop: begin
        mem_rd_en = 1'b1;
        shreg_d   = mem_rd_data;
        baud_d    = '0;
        bit_d     = '0;
        byte_d    = '0;
        state_d   = StSend;
      end
      StSend: begin
        baud_d = baud_q + CW'(1);
        if (baud_q == CW'(CLKS_PER_BIT - 1)) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d   = '0;
            byte_d  = byte_q + 2'd1;
            shreg_d = {8'h00, shreg_q[31:8]};
`ifdef UART_DUMP_CHECKSUM_EN
            if (trailer_q) begin
              dump_done = (byte_q == 2'd1);
            end else begin
              sum_d     = sum_q + {8'h00, shreg_q[7:0]};
              sent_d    = sent_q + AW'(1);
              word_done = (byte_q == 2'd3);
            end
`else
            sent_d    = sent_q + AW'(1);
            word_done = (byte_q == 2'd3);
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (word_done) begin
      if (word_q != WW'(BURST_WORDS - 1)) begin
        word_d  = word_q + WW'(1);
        state_d = StWait;
      end else begin
        word_d = '0;
        if (burst_q != BIW'(NUM_BURSTS - 1)) begin
          burst_d = burst_q + BIW'(1);
          state_d = StCmd;
        end else begin
`ifdef UART_DUMP_CHECKSUM_EN
          // Stay in StSend; the two trailer frames follow back-to-back.
          trailer_d = 1'b1;
          byte_d    = '0;
          shreg_d   = {16'h0000, sum_d[7:0], sum_d[15:8]};
`else
          dump_done = 1'b1;
`endif
        end
      end
    end

    if (dump_done) begin
      state_d = StDone;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
      sum_q     <= '0;
      trailer_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_q | mem_rd_overflow | mem_rd_error;
`ifdef UART_DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
      trailer_q <= trailer_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_dumper.sv
// Directed bench for uart_dumper: behavioural MCB read port, 8N1 line receiver, fast baud.

module tb_uart_dumper;

  localparam int unsigned CLK_FREQ    = 4;
  localparam int unsigned BAUD        = 1;
  localparam int unsigned CPB         = CLK_FREQ / BAUD;
  localparam int unsigned FRAME       = 10 * CPB;
  localparam int unsigned DUMP_BYTES  = 256;
  localparam int unsigned BURST_WORDS = 16;
`ifdef UART_DUMP_CHECKSUM_EN
  localparam int unsigned NFRAMES = DUMP_BYTES + 2;
`else
  localparam int unsigned NFRAMES = DUMP_BYTES;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        calib_done = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error, uart_tx;
  logic [7:0]  progress;
  logic        mem_cmd_en, mem_rd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_empty = 1'b1;
  logic        mem_cmd_full = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_full = 1'b0;
  logic        mem_rd_empty = 1'b1;
  logic [6:0]  mem_rd_count = '0;
  logic        mem_rd_overflow = 1'b0;
  logic        mem_rd_error = 1'b0;

  always #5 clk = ~clk;

  uart_dumper #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .BASE_ADDR  (0),
    .DUMP_BYTES (DUMP_BYTES),
    .BURST_WORDS(BURST_WORDS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .calib_done       (calib_done),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .progress         (progress),
    .uart_tx          (uart_tx),
    .mem_cmd_en       (mem_cmd_en),
    .mem_cmd_instr    (mem_cmd_instr),
    .mem_cmd_bl       (mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_cmd_empty    (mem_cmd_empty),
    .mem_cmd_full     (mem_cmd_full),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_data      (mem_rd_data),
    .mem_rd_full      (mem_rd_full),
    .mem_rd_empty     (mem_rd_empty),
    .mem_rd_count     (mem_rd_count),
    .mem_rd_overflow  (mem_rd_overflow),
    .mem_rd_error     (mem_rd_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // RAM content: byte at address b is (b+1)*17, so word 0 is 32'h44332211.
  bit all_ff = 1'b0;
  function automatic logic [7:0] byte_at(input int unsigned b);
    return all_ff ? 8'hFF : 8'((b + 1) * 17);
  endfunction

  // MCB model: outputs sampled mid-cycle, effects applied just after the next rising edge.
  logic [31:0] fifo_q[$];
  logic [29:0] cmd_log[$];
  bit          rd_en_s, cmd_en_s;
  logic [29:0] cmd_addr_s;
  int          pend_words = 0, fill_delay = 0, fifo_max = 0, viol = 0, underflow = 0;
  int unsigned fill_addr = 0;

  always @(negedge clk) begin
    rd_en_s    = (mem_rd_en === 1'b1);
    cmd_en_s   = (mem_cmd_en === 1'b1);
    cmd_addr_s = mem_cmd_byte_addr;
    if (cmd_en_s && mem_cmd_full) viol++;
  end

  always @(posedge clk) begin
    #1;
    if (rd_en_s) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      else underflow++;
    end
    if (cmd_en_s) begin
      cmd_log.push_back(cmd_addr_s);
      pend_words += BURST_WORDS;
      fill_addr  = cmd_addr_s;
      fill_delay = 6;
    end else if (fill_delay > 0) begin
      fill_delay--;
    end else if (pend_words > 0) begin
      fifo_q.push_back({byte_at(fill_addr + 3), byte_at(fill_addr + 2),
                        byte_at(fill_addr + 1), byte_at(fill_addr)});
      fill_addr += 4;
      pend_words--;
    end
    if (fifo_q.size() > fifo_max) fifo_max = fifo_q.size();
    mem_rd_empty = (fifo_q.size() == 0);
    mem_rd_data  = mem_rd_empty ? 32'h0 : fifo_q[0];
    mem_rd_count = 7'(fifo_q.size());
    mem_rd_full  = (fifo_q.size() >= 64);
  end

  // Line receiver: checks every bit is flat for CPB cycles and the decoded byte.
  int          rx_n = 0, rx_cnt = 0, rx_k, rx_pos, prev_start = 0;
  bit          rx_active = 1'b0, rx_bad, rx_stop;
  logic        rx_lvl;
  logic [7:0]  rx_byte, rx_exp;
  logic [15:0] exp_sum = '0;
  logic [7:0]  rx_log[NFRAMES];

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_bad    = 1'b0;
        check_eq("progress", progress, (rx_n >= DUMP_BYTES) ? 8'hFF : 8'(rx_n));
        if (rx_n % 4 != 0 && rx_n < DUMP_BYTES) check_eq("b2b_gap", cyc - prev_start, FRAME);
        prev_start = cyc;
      end
      if (rx_active) begin
        rx_k   = rx_cnt / CPB;
        rx_pos = rx_cnt % CPB;
        if (rx_pos == 0) rx_lvl = uart_tx;
        else if (uart_tx !== rx_lvl) rx_bad = 1'b1;
        if (rx_pos == CPB / 2 && rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = uart_tx;
        if (rx_k == 9 && rx_pos == 0) rx_stop = uart_tx;
        if (rx_cnt == FRAME - 1) begin
          if (rx_n < DUMP_BYTES) begin
            rx_exp  = byte_at(rx_n);
            exp_sum = exp_sum + {8'h00, rx_exp};
          end else if (rx_n == DUMP_BYTES) begin
            rx_exp = exp_sum[15:8];
          end else begin
            rx_exp = exp_sum[7:0];
          end
          check_eq("frame_timing", {30'd0, rx_bad, rx_stop}, 32'd1);
          check_eq("rx_byte", rx_byte, rx_exp);
          if (rx_n < NFRAMES) rx_log[rx_n] = rx_byte;
          rx_n++;
          rx_active = 1'b0;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic begin_dump(input bit ff);
    all_ff  = ff;
    rx_n    = 0;
    exp_sum = '0;
    cmd_log.delete();
    pulse_start();
  endtask

  task automatic wait_frames(input int n);
    int budget = (n + 2) * FRAME * 2 + 200;
    while (rx_n < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("frames_reached", 32'(rx_n >= n), 32'd1);
  endtask

  task automatic wait_done();
    int budget = 500;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("done", done, 1'b1);
    check_eq("busy_after_done", busy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_uart_tx", uart_tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_progress", progress, 8'h00);
    check_eq("rst_cmd_en", mem_cmd_en, 1'b0);
    check_eq("rst_rd_en", mem_rd_en, 1'b0);
    check_eq("cmd_instr", mem_cmd_instr, 3'b001);
    check_eq("cmd_bl", mem_cmd_bl, 6'd15);

    // start without calibration is ignored
    pulse_start();
    repeat (20) @(negedge clk);
    check_eq("nocal_busy", busy, 1'b0);
    check_eq("nocal_cmds", cmd_log.size(), 0);
    @(posedge clk); #1 calib_done = 1'b1;

    // Dump 1: pattern data, plus a start while busy
    begin_dump(1'b0);
    wait_frames(20);
    pulse_start();
    wait_frames(NFRAMES);
    wait_done();
    check_eq("d1_frames", rx_n, NFRAMES);
    check_eq("d1_cmds", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("d1_cmd_addr", cmd_log[i], 30'(64 * i));
    check_eq("d1_byte0", rx_log[0], 8'h11);
    check_eq("d1_byte1", rx_log[1], 8'h22);
    check_eq("d1_byte2", rx_log[2], 8'h33);
    check_eq("d1_byte3", rx_log[3], 8'h44);
    check_eq("d1_byte84", rx_log[84], 8'hA5);
    repeat (30) @(negedge clk);
    check_eq("d1_no_restart", busy, 1'b0);
    check_eq("d1_done_held", done, 1'b1);

    // Dump 2: command FIFO full for 50 cycles
    @(posedge clk); #1 mem_cmd_full = 1'b1;
    begin_dump(1'b0);
    repeat (50) @(negedge clk);
    check_eq("full_no_cmd", cmd_log.size(), 0);
    check_eq("full_busy", busy, 1'b1);
    check_eq("full_done_clr", done, 1'b0);
    @(posedge clk); #1 mem_cmd_full = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("full_one_cmd", cmd_log.size(), 1);
    wait_frames(NFRAMES);
    wait_done();
    check_eq("d2_cmds", cmd_log.size(), 4);

    // Dump 3: reset three words into the first burst, stale words must be drained
    begin_dump(1'b0);
    wait_frames(10);
    pulse_reset();
    check_eq("abort_uart_tx", uart_tx, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    for (int i = 0; i < 100 && (fifo_q.size() != 0 || pend_words != 0); i++) @(negedge clk);
    check_eq("abort_drained", fifo_q.size(), 0);

    // Dump 4: clean dump after the abort
    begin_dump(1'b0);
    wait_frames(NFRAMES);
    wait_done();
    check_eq("d4_frames", rx_n, NFRAMES);
    check_eq("d4_byte0", rx_log[0], 8'h11);
    check_eq("d4_cmds", cmd_log.size(), 4);

    // Dump 5: all-0xFF data with a read error mid-dump
    begin_dump(1'b1);
    wait_frames(5);
    @(posedge clk); #1 mem_rd_error = 1'b1;
    @(posedge clk); #1 mem_rd_error = 1'b0;
    @(negedge clk);
    check_eq("error_set", error, 1'b1);
    wait_frames(NFRAMES);
    wait_done();
    check_eq("error_sticky", error, 1'b1);
    check_eq("d5_last_byte", rx_log[DUMP_BYTES-1], 8'hFF);
    pulse_reset();
    check_eq("error_cleared", error, 1'b0);
    @(posedge clk); #1 mem_rd_overflow = 1'b1;
    @(posedge clk); #1 mem_rd_overflow = 1'b0;
    @(negedge clk);
    check_eq("overflow_err", error, 1'b1);

    check_eq("cmd_while_full", viol, 0);
    check_eq("rd_underflow", underflow, 0);
    check_eq("fifo_bound", 32'(fifo_max <= BURST_WORDS), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
